// File: rtl/pc_ctrl_if.sv
// Signal bundle between the rv32i datapath/pc register and the next-PC sequencer.
// The slave side is the sequencer; the master side is whatever drives it.
interface pc_ctrl_if;
   logic [31:0] pc_in;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        halt_req;
   logic [31:0] next_pc;
   logic        trap;
   logic [31:0] epc;
   logic [3:0]  cause;
   logic        halted;
   logic        booting;
   logic [31:0] instret;

   modport slave (
      input  pc_in, stall, branch_taken, branch_target, jump, jump_target, halt_req,
      output next_pc, trap, epc, cause, halted, booting, instret
   );

   modport master (
      output pc_in, stall, branch_taken, branch_target, jump, jump_target, halt_req,
      input  next_pc, trap, epc, cause, halted, booting, instret
   );
endinterface

// File: rtl/pc_ctrl.sv
// Next-PC sequencer: boot hold, redirect arbitration with misalignment traps,
// stall/halt handling and retired-instruction counting.
module pc_ctrl #(
   parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
   parameter int          BOOT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   pc_ctrl_if.slave    bus
);

   localparam logic [7:0] LP_BOOT_LAST = 8'(BOOT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_boot_cnt;
   logic [7:0]  w_boot_cnt_next;
   logic [31:0] r_epc;
   logic [3:0]  r_cause;
   logic [31:0] r_instret;

   logic [31:0] w_next_pc;
   logic        w_trap;
   logic        w_retire;
   logic        w_redirect;
   logic [31:0] w_candidate;

   // jump outranks branch when both are asserted
   assign w_redirect  = bus.jump | bus.branch_taken;
   assign w_candidate = bus.jump ? bus.jump_target : bus.branch_target;

   always_comb begin
      w_state_next    = r_state;
      w_boot_cnt_next = r_boot_cnt;
      w_next_pc       = RESET_VEC;
      w_trap          = 1'b0;
      w_retire        = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_next_pc = RESET_VEC;
            if (r_boot_cnt == LP_BOOT_LAST) begin
               w_state_next = ST_RUN;
            end else begin
               w_boot_cnt_next = r_boot_cnt + 8'd1;
            end
         end
         ST_RUN: begin
            if (bus.halt_req) begin
               w_next_pc    = bus.pc_in;
               w_state_next = ST_HALT;
            end else if (bus.stall) begin
               w_next_pc = bus.pc_in;
            end else if (w_redirect) begin
               if (w_candidate[1:0] != 2'b00) begin
                  w_next_pc = TRAP_VEC;
                  w_trap    = 1'b1;
               end else begin
                  w_next_pc = w_candidate;
                  w_retire  = 1'b1;
               end
            end else begin
               w_next_pc = bus.pc_in + 32'd4;
               w_retire  = 1'b1;
            end
         end
         ST_HALT: begin
            w_next_pc = bus.pc_in;
         end
         default: begin
            w_next_pc    = RESET_VEC;
            w_state_next = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_BOOT;
         r_boot_cnt <= 8'd0;
         r_epc      <= 32'd0;
         r_cause    <= 4'd0;
         r_instret  <= 32'd0;
      end else begin
         r_state    <= w_state_next;
         r_boot_cnt <= w_boot_cnt_next;
         if (w_trap) begin
            r_epc   <= bus.pc_in;
            r_cause <= 4'd0;
         end
         if (w_retire) begin
            r_instret <= r_instret + 32'd1;
         end
      end
   end

   assign bus.next_pc = w_next_pc;
   assign bus.trap    = w_trap;
   assign bus.epc     = r_epc;
   assign bus.cause   = r_cause;
   assign bus.halted  = (r_state == ST_HALT);
   assign bus.booting = (r_state == ST_BOOT);
   assign bus.instret = r_instret;

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Next-PC sequencer for the rv32i single-cycle core. It sits in front of the pc register and drives that register's next_pc input every cycle. It arbitrates among sequential fetch, branch, jump and jalr redirects, and holds the PC during stalls. It handles boot delay after reset, misaligned-target traps (with exception PC and cause capture), halt, and counting of retired instructions.

Parameters:
RESET_VEC, 32'h0000_0000, PC value driven during boot.
TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap.
BOOT_CYCLES, 4, number of cycles next_pc is held at RESET_VEC after reset release (legal range 1..255).

Ports:
clk  in  1  core clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
pc_in  in  32  current PC (the pc register's pc_out).
stall  in  1  hold the PC this cycle.
branch_taken  in  1  conditional branch resolved taken.
branch_target  in  32  branch target address.
jump  in  1  jal or jalr redirect.
jump_target  in  32  jump target address (jalr LSB already cleared by the datapath).
halt_req  in  1  ecall/ebreak: stop fetching.
next_pc  out  32  value for the pc register to load on the next edge.
trap  out  1  one-cycle pulse when a misaligned redirect is converted to a trap.
epc  out  32  PC of the instruction that trapped.
cause  out  4  trap cause (4'd0 = instruction address misaligned).
halted  out  1  high while in HALT.
booting  out  1  high while in BOOT.
instret  out  32  retired-instruction counter.

Behaviour:
- Reset (reset=0, asynchronous): state=BOOT, boot counter=0, epc=0, cause=0, instret=0. Outputs are then halted=0, booting=1, trap=0, next_pc=RESET_VEC.
- FSM states: BOOT, RUN, HALT. All registered state updates occur on the rising clk edge. next_pc and trap are combinational from the current state and inputs.
- BOOT:
  - next_pc=RESET_VEC; all other inputs are ignored.
  - The counter increments each cycle. When the counter reaches BOOT_CYCLES-1, the next state is RUN.
  - booting stays high for exactly BOOT_CYCLES cycles after reset release.
- RUN priority, highest first:
  1. halt_req: next_pc=pc_in, next state HALT, no instret increment.
  2. stall: next_pc=pc_in. Redirect inputs are ignored; upstream holds them until the stall drops.
  3. jump: candidate target = jump_target.
  4. branch_taken: candidate target = branch_target.
  5. Otherwise: next_pc = pc_in + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0). Sequential fetch never traps.
- Redirect check (cases 3 and 4):
  - If candidate[1:0] != 2'b00: next_pc=TRAP_VEC, trap=1, epc<=pc_in, cause<=4'd0, no instret increment.
  - Otherwise: next_pc=candidate and instret increments.
  - jump and branch_taken asserted together: jump wins.
- instret:
  - Increments by 1 in RUN on every non-stalled, non-halt, non-trap cycle.
  - Wraps 32'hFFFF_FFFF to 0.
- HALT:
  - next_pc=pc_in (PC frozen), halted=1, all inputs ignored.
  - Exit only through reset.
- epc and cause hold their values until the next trap or reset.
- Reset asserted mid-operation (any state) takes effect immediately: outputs return to their reset values without waiting for a clock edge.
- No combinational path from next_pc back to pc_in inside this block.

Test Plan:
1. Reset low for 2 cycles, then release with defaults: next_pc=0 and booting=1 for exactly 4 cycles, then RUN. With pc_in=0, next_pc=0x4.
2. RUN, pc_in=0x10, no requests: next_pc=0x14 and instret increments. Then stall=1 with jump=1 and jump_target=0x40: next_pc=0x10 and instret is unchanged.
3. pc_in=0x20, jump=1 with jump_target=0x80, branch_taken=1 with branch_target=0x24: next_pc=0x80. Then jump=0, branch_taken=1 with branch_target=0x24: next_pc=0x24.
4. pc_in=0x30, branch_taken=1, branch_target=0x36: next_pc=0x100, trap pulses for 1 cycle, epc=0x30, cause=0, instret unchanged.
5. halt_req=1 at pc_in=0x50: halted=1 from the next cycle. With pc_in=0x50 held, next_pc stays 0x50 for 10 cycles despite jump=1 (jump_target=0x80). Then reset: booting=1, next_pc=0.
6. pc_in=32'hFFFF_FFFC sequential: next_pc=0. Separately, reset asserted mid-stream between clock edges: halted, trap and instret go to 0 and next_pc goes to RESET_VEC immediately.
